m9k_tensor_reader: RTL and testbench

Initiator on the M9K memory port: given a base word address, walks one tensor record (header then elements) and streams the elements out over a valid/ready interface. It drives the same addr/w_en/data_store/data_load port the M9K controller responds to, and feeds compute units that consume operand tensors. Read-only; owns the memory port while busy.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/tensor_count_acc.sv | 29 ++
 rtl/m9k_tensor_reader.sv | 163 ++++++++++++++++
 tb/tb_m9k_tensor_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-port package.
// Holds the tensor reader state encoding, the maximum legal tensor rank and
// the word offsets of the fields inside a tensor record header.
package mem_pkg;

    // Reader FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_N   = 3'd1,
        ST_HDR_DIM = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } reader_state_t;

    // Largest rank a record may declare.
    localparam int MAX_DIMS = 4;

    // Header layout: ndims word first, dimension sizes directly after it.
    localparam int NDIMS_OFS = 0;
    localparam int DIMS_OFS  = 1;

endpackage

// File: rtl/tensor_count_acc.sv
// Element-count accumulator step.
// Multiplies the running element count by one dimension size and flags any
// result that cannot describe a tensor fitting in the address space.
// Ports:
//   i_count    running element count (ADDR_W+1 bits, at most 2^ADDR_W)
//   i_dim      dimension size read from the header
//   o_product  i_count * i_dim, truncated to ADDR_W+1 bits
//   o_overflow dimension is zero, or the product exceeds 2^ADDR_W
module tensor_count_acc #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W:0]   i_count,
    input  logic [DATA_W-1:0] i_dim,
    output logic [ADDR_W:0]   o_product,
    output logic              o_overflow
);

    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(1) << ADDR_W;

    logic [DATA_W-1:0] w_full;

    // Any dim above the limit already overflows because i_count >= 1; ruling
    // it out first also keeps the DATA_W-wide product from wrapping.
    assign w_full     = DATA_W'(i_count) * i_dim;
    assign o_product  = w_full[ADDR_W:0];
    assign o_overflow = (i_dim == '0) || (i_dim > LIMIT) || (w_full > LIMIT);

endmodule

// File: rtl/m9k_tensor_reader.sv
// Tensor record reader on the M9K memory port.
// Walks one record (ndims word, dimension words, element words) starting at
// cmd_base and streams the elements over a valid/ready interface. Read-only.
// Ports:
//   clk, rst_l                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_base   start request; ready only while idle
//   mem_addr/mem_w_en/
//   mem_data_store/mem_data_load   memory port (combinational read data)
//   elem_valid/elem_ready/
//   elem_data/elem_last            element stream
//   done/err/end_addr              end-of-record pulse, error flag, and the
//                                  first address after the record
module m9k_tensor_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int MAX_DIMS = mem_pkg::MAX_DIMS
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] mem_data_store,
    input  logic [DATA_W-1:0] mem_data_load,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic [DATA_W-1:0] elem_data,
    output logic              elem_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] end_addr
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int DIMC_W = $clog2(MAX_DIMS + 1);
    localparam logic [CNT_W-1:0] LIMIT = {1'b1, {ADDR_W{1'b0}}};

    reader_state_t     r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_remaining;
    logic [DIMC_W-1:0] r_dims_left;
    logic              r_err;
    logic [ADDR_W-1:0] r_end_addr;

    logic [CNT_W-1:0]  w_product;
    logic              w_overflow;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [DATA_W:0]   w_hdr_end;
    logic              w_hdr_bad;
    logic [ADDR_W+1:0] w_data_end;
    logic              w_data_bad;
    logic              w_active;

    tensor_count_acc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_count_acc (
        .i_count    (r_count),
        .i_dim      (mem_data_load),
        .o_product  (w_product),
        .o_overflow (w_overflow)
    );

    assign w_ptr_inc = r_ptr + ADDR_W'(1);

    // The last dimension word must still lie inside the address space.
    assign w_hdr_end = (DATA_W+1)'(r_ptr) + (DATA_W+1)'(mem_data_load);
    assign w_hdr_bad = (mem_data_load == '0)
                    || (mem_data_load > DATA_W'(MAX_DIMS))
                    || (w_hdr_end > (DATA_W+1)'((2 ** ADDR_W) - 1));

    // Element block starts right after the last dimension word; its end may
    // touch 2^ADDR_W exactly but not go beyond.
    assign w_data_end = (ADDR_W+2)'(r_ptr) + (ADDR_W+2)'(1) + (ADDR_W+2)'(w_product);
    assign w_data_bad = w_data_end > (ADDR_W+2)'(LIMIT);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_dims_left <= '0;
            r_err       <= 1'b0;
            r_end_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_ptr   <= cmd_base + ADDR_W'(NDIMS_OFS);
                        r_err   <= 1'b0;
                        r_state <= ST_HDR_N;
                    end
                end
                ST_HDR_N: begin
                    if (w_hdr_bad) begin
                        r_err      <= 1'b1;
                        r_end_addr <= r_ptr;
                        r_state    <= ST_DONE;
                    end else begin
                        r_count     <= CNT_W'(1);
                        r_ptr       <= r_ptr + ADDR_W'(DIMS_OFS);
                        r_dims_left <= mem_data_load[DIMC_W-1:0];
                        r_state     <= ST_HDR_DIM;
                    end
                end
                ST_HDR_DIM: begin
                    if (w_overflow) begin
                        r_err      <= 1'b1;
                        r_end_addr <= r_ptr;
                        r_state    <= ST_DONE;
                    end else begin
                        r_count     <= w_product;
                        r_ptr       <= w_ptr_inc;
                        r_dims_left <= r_dims_left - DIMC_W'(1);
                        if (r_dims_left == DIMC_W'(1)) begin
                            if (w_data_bad) begin
                                r_err      <= 1'b1;
                                r_end_addr <= w_ptr_inc;
                                r_state    <= ST_DONE;
                            end else begin
                                r_remaining <= w_product;
                                r_state     <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (elem_ready) begin
                        r_ptr       <= w_ptr_inc;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_end_addr <= w_ptr_inc;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign w_active       = (r_state == ST_HDR_N) || (r_state == ST_HDR_DIM)
                         || (r_state == ST_DATA);
    assign cmd_ready      = (r_state == ST_IDLE);
    assign mem_addr       = w_active ? r_ptr : '0;
    assign mem_w_en       = 1'b0;
    assign mem_data_store = '0;
    assign elem_valid     = (r_state == ST_DATA);
    assign elem_data      = elem_valid ? mem_data_load : '0;
    assign elem_last      = elem_valid && (r_remaining == CNT_W'(1));
    assign done           = (r_state == ST_DONE);
    assign err            = done && r_err;
    assign end_addr       = r_end_addr;

endmodule

// File: tb/tb_m9k_tensor_reader.sv
module tb_m9k_tensor_reader;

    logic        clk;
    logic        rst_l;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_base;
    logic [14:0] mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_data_store;
    logic [31:0] mem_data_load;
    logic        elem_valid;
    logic        elem_ready;
    logic [31:0] elem_data;
    logic        elem_last;
    logic        done;
    logic        err;
    logic [14:0] end_addr;

    logic [31:0] tb_mem [64];
    int pass_cnt = 0;
    int total_cnt = 0;

    m9k_tensor_reader #(.ADDR_W(15), .DATA_W(32), .MAX_DIMS(4)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base       (cmd_base),
        .mem_addr       (mem_addr),
        .mem_w_en       (mem_w_en),
        .mem_data_store (mem_data_store),
        .mem_data_load  (mem_data_load),
        .elem_valid     (elem_valid),
        .elem_ready     (elem_ready),
        .elem_data      (elem_data),
        .elem_last      (elem_last),
        .done           (done),
        .err            (err),
        .end_addr       (end_addr)
    );

    assign mem_data_load = (mem_addr < 15'd64) ? tb_mem[mem_addr[5:0]] : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one command in IDLE; returns at the negedge of the HDR_N cycle.
    task automatic issue_cmd(input logic [14:0] base);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = base;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; cmd_valid = 1'b0; cmd_base = '0; elem_ready = 1'b1;
        #1;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (mem_addr !== 15'd0) $display("FAIL reset_mem_addr got %0d want 0", mem_addr); else pass_cnt++;
        total_cnt++; if ({elem_valid, elem_last, done, err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {elem_valid, elem_last, done, err}); else pass_cnt++;
        total_cnt++; if (end_addr !== 15'd0) $display("FAIL reset_end_addr got %0d want 0", end_addr); else pass_cnt++;
        total_cnt++; if (mem_w_en !== 1'b0 || mem_data_store !== 32'd0) $display("FAIL reset_write_port got %0b/%0d want 0/0", mem_w_en, mem_data_store); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", cmd_ready); else pass_cnt++;
        $display("reset: released, cmd_ready=%0b", cmd_ready);
    endtask

    task automatic test_basic();
        logic [14:0] bases [2];
        int firsts [2];
        logic [14:0] ends [2];
        bases = '{15'd0, 15'd7}; firsts = '{1, 6}; ends = '{15'd7, 15'd14};
        for (int r = 0; r < 2; r++) begin
            issue_cmd(bases[r]);
            total_cnt++; if (mem_addr !== bases[r] || cmd_ready !== 1'b0) $display("FAIL basic_hdr_n addr got %0d want %0d ready %0b", mem_addr, bases[r], cmd_ready); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (elem_valid !== 1'b0 || mem_addr !== bases[r] + 15'd1) $display("FAIL basic_hdr_dim valid %0b addr got %0d want %0d", elem_valid, mem_addr, bases[r] + 15'd1); else pass_cnt++;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                total_cnt++;
                if (elem_valid !== 1'b1 || elem_data !== 32'(firsts[r] + i) || elem_last !== (i == 4) || mem_addr !== bases[r] + 15'd2 + 15'(i))
                    $display("FAIL basic_elem base %0d idx %0d got v=%0b d=%0d l=%0b a=%0d want v=1 d=%0d l=%0b a=%0d",
                             bases[r], i, elem_valid, elem_data, elem_last, mem_addr, firsts[r] + i, (i == 4), bases[r] + 15'd2 + 15'(i));
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++; if (done !== 1'b1 || err !== 1'b0 || elem_valid !== 1'b0) $display("FAIL basic_done got done=%0b err=%0b v=%0b want 1/0/0", done, err, elem_valid); else pass_cnt++;
            total_cnt++; if (end_addr !== ends[r]) $display("FAIL basic_end_addr got %0d want %0d", end_addr, ends[r]); else pass_cnt++;
            $display("basic: base %0d streamed, end_addr=%0d", bases[r], end_addr);
        end
    endtask

    // Runs base 7, then holds cmd_valid from the DONE cycle on; it must be
    // taken only in the IDLE cycle that follows.
    task automatic test_back_to_back();
        issue_cmd(15'd7);
        repeat (7) @(negedge clk);
        total_cnt++; if (done !== 1'b1 || end_addr !== 15'd14) $display("FAIL b2b_first_done got done=%0b end=%0d want 1/14", done, end_addr); else pass_cnt++;
        cmd_valid = 1'b1; cmd_base = 15'd0;
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL b2b_idle got ready=%0b done=%0b want 1/0", cmd_ready, done); else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_accept got ready=%0b want 0", cmd_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mem_addr !== 15'd1) $display("FAIL b2b_hdr_dim addr got %0d want 1", mem_addr); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++; if (elem_valid !== 1'b1 || elem_data !== 32'(i + 1)) $display("FAIL b2b_elem idx %0d got v=%0b d=%0d want 1/%0d", i, elem_valid, elem_data, i + 1); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || end_addr !== 15'd7) $display("FAIL b2b_done got done=%0b err=%0b end=%0d want 1/0/7", done, err, end_addr); else pass_cnt++;
        $display("back_to_back: second record done, end_addr=%0d", end_addr);
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int hs, j;
        logic saw_done;
        pat = 4'b1001; hs = 0; j = 0; saw_done = 1'b0;
        issue_cmd(15'd0);
        for (int c = 0; c < 60 && !saw_done; c++) begin
            if (elem_valid) begin
                elem_ready = pat[j % 4];
                j++;
                #1;
                total_cnt++;
                if (elem_data !== 32'(hs + 1) || mem_addr !== 15'(2 + hs) || elem_last !== (hs == 4))
                    $display("FAIL stall_elem hs %0d got d=%0d a=%0d l=%0b want d=%0d a=%0d l=%0b",
                             hs, elem_data, mem_addr, elem_last, hs + 1, 2 + hs, (hs == 4));
                else pass_cnt++;
                if (elem_ready) hs++;
            end else if (done) begin
                saw_done = 1'b1;
                total_cnt++; if (err !== 1'b0 || end_addr !== 15'd7) $display("FAIL stall_done got err=%0b end=%0d want 0/7", err, end_addr); else pass_cnt++;
            end
            @(negedge clk);
        end
        elem_ready = 1'b1;
        total_cnt++; if (hs !== 5 || saw_done !== 1'b1) $display("FAIL stall_count got hs=%0d done=%0b want 5/1", hs, saw_done); else pass_cnt++;
        $display("stall: %0d handshakes over %0d valid cycles", hs, j);
    endtask

    task automatic test_errors();
        logic [14:0] bases [4];
        int dcyc [4];
        logic [14:0] ends [4];
        int got_c;
        logic saw_v;
        logic err_s;
        bases = '{15'd20, 15'd22, 15'd30, 15'd40};
        dcyc  = '{2, 2, 4, 4};
        ends  = '{15'd20, 15'd22, 15'd32, 15'd42};
        for (int t = 0; t < 4; t++) begin
            issue_cmd(bases[t]);
            got_c = 0; saw_v = 1'b0; err_s = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                if (elem_valid) saw_v = 1'b1;
                if (done) begin
                    got_c = c;
                    err_s = err;
                    break;
                end
                @(negedge clk);
            end
            total_cnt++; if (got_c !== dcyc[t]) $display("FAIL err_done_cycle base %0d got %0d want %0d", bases[t], got_c, dcyc[t]); else pass_cnt++;
            total_cnt++; if (err_s !== 1'b1 || saw_v !== 1'b0) $display("FAIL err_flag base %0d got err=%0b saw_valid=%0b want 1/0", bases[t], err_s, saw_v); else pass_cnt++;
            total_cnt++; if (end_addr !== ends[t]) $display("FAIL err_end_addr base %0d got %0d want %0d", bases[t], end_addr, ends[t]); else pass_cnt++;
            $display("errors: base %0d done at cycle %0d err=%0b end_addr=%0d", bases[t], got_c, err_s, end_addr);
        end
    endtask

    task automatic test_mid_reset();
        issue_cmd(15'd0);
        repeat (4) @(negedge clk);
        total_cnt++; if (elem_valid !== 1'b1 || elem_data !== 32'd3) $display("FAIL midrst_pre got v=%0b d=%0d want 1/3", elem_valid, elem_data); else pass_cnt++;
        rst_l = 1'b0;
        #1;
        total_cnt++; if (elem_valid !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== 15'd0 || done !== 1'b0)
            $display("FAIL midrst_async got v=%0b r=%0b a=%0d done=%0b want 0/1/0/0", elem_valid, cmd_ready, mem_addr, done); else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++; if (done !== 1'b0 || elem_valid !== 1'b0) $display("FAIL midrst_hold got done=%0b v=%0b want 0/0", done, elem_valid); else pass_cnt++;
        end
        rst_l = 1'b1;
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL midrst_release got r=%0b done=%0b want 1/0", cmd_ready, done); else pass_cnt++;
        issue_cmd(15'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++; if (elem_valid !== 1'b1 || elem_data !== 32'(i + 1)) $display("FAIL midrst_elem idx %0d got v=%0b d=%0d want 1/%0d", i, elem_valid, elem_data, i + 1); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || end_addr !== 15'd7) $display("FAIL midrst_done got done=%0b err=%0b end=%0d want 1/0/7", done, err, end_addr); else pass_cnt++;
        $display("mid_reset: fresh record done, end_addr=%0d", end_addr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'd0;
        tb_mem[0] = 1;  tb_mem[1] = 5;
        for (int i = 0; i < 5; i++) tb_mem[2 + i] = 32'(i + 1);
        tb_mem[7] = 1;  tb_mem[8] = 5;
        for (int i = 0; i < 5; i++) tb_mem[9 + i] = 32'(i + 6);
        tb_mem[20] = 0;
        tb_mem[22] = 5;
        tb_mem[30] = 2; tb_mem[31] = 200; tb_mem[32] = 200;
        tb_mem[40] = 2; tb_mem[41] = 3;   tb_mem[42] = 0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_errors();
        test_mid_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
